// File: rtl/miriscv_lsu_pkg.sv
// Shared types for the MIRISCV load/store unit: access size encoding (funct3),
// FSM state encoding and a helper giving the byte count of an access size.
package miriscv_lsu_pkg;

  // funct3 encoding of the access size; 7 is never a legal access.
  typedef enum logic [2:0] {
    SZ_B   = 3'd0,
    SZ_H   = 3'd1,
    SZ_W   = 3'd2,
    SZ_D   = 3'd3,
    SZ_BU  = 3'd4,
    SZ_HU  = 3'd5,
    SZ_WU  = 3'd6,
    SZ_RSV = 3'd7
  } lsu_size_e;

  // Handshake sequencing: accept in IDLE, hold request in ISSUE until grant,
  // wait for the response in WAIT, release the core for one cycle in DONE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_e;

  // Number of bytes touched by an access of the given size.
  function automatic logic [3:0] size_bytes(lsu_size_e sz);
    case (sz)
      SZ_H, SZ_HU: return 4'd2;
      SZ_W, SZ_WU: return 4'd4;
      SZ_D:        return 4'd8;
      default:     return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/miriscv_lsu_hs_if.sv
// Memory-side request/grant/response bus of the load/store unit.
// The LSU is the master; the memory (or bench) is the slave.
interface miriscv_lsu_hs_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [XLEN/8-1:0] be;
  logic [XLEN-1:0]   wdata;
  logic              gnt;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/miriscv_lsu_align.sv
// Combinational lane logic for the LSU: legality and byte enables of a new
// request, store data replication, and load lane extraction with extension.
module miriscv_lsu_align
  import miriscv_lsu_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int BE_W  = XLEN / 8,
  localparam int OFF_W = $clog2(BE_W)
) (
  // request side (live core inputs)
  input  lsu_size_e        req_size_i,
  input  logic [OFF_W-1:0] req_off_i,
  input  logic [XLEN-1:0]  req_data_i,
  output logic             req_legal_o,
  output logic [BE_W-1:0]  req_be_o,
  output logic [XLEN-1:0]  req_wdata_o,
  // response side (registered attributes of the outstanding access)
  input  lsu_size_e        rsp_size_i,
  input  logic [OFF_W-1:0] rsp_off_i,
  input  logic [XLEN-1:0]  rsp_rdata_i,
  output logic [XLEN-1:0]  rsp_data_o
);

  logic [3:0]      req_off4;
  logic [3:0]      req_mask;
  logic            size_unsupported;
  logic [XLEN-1:0] rsp_lane;

  // Offset widened to 4 bits so one alignment test serves both data widths.
  assign req_off4 = 4'(req_off_i);
  assign req_mask = size_bytes(req_size_i) - 4'd1;

  // Legality: size 7 never exists, D/WU only exist on a 64-bit datapath,
  // and every access must be naturally aligned.
  always_comb begin
    size_unsupported = (req_size_i == SZ_RSV) ||
                       ((XLEN == 32) && ((req_size_i == SZ_D) || (req_size_i == SZ_WU)));
    req_legal_o      = !size_unsupported && ((req_off4 & req_mask) == 4'd0);
  end

  // Byte enables: a run of size_bytes ones starting at the byte offset.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    req_be_o = '0;
    case (req_size_i)
      SZ_B, SZ_BU: req_be_o = BE_W'(1)  << req_off_i;
      SZ_H, SZ_HU: req_be_o = BE_W'(3)  << req_off_i;
      SZ_W, SZ_WU: req_be_o = BE_W'(15) << req_off_i;
      SZ_D:        req_be_o = '1;
      default:     req_be_o = '0;
    endcase
  end

  // Store data: low bytes replicated across every lane so the memory picks
  // the right copy with the byte enables alone.
  always_comb begin
    req_wdata_o = req_data_i;
    case (req_size_i)
      SZ_B, SZ_BU: req_wdata_o = {(XLEN/8){req_data_i[7:0]}};
      SZ_H, SZ_HU: req_wdata_o = {(XLEN/16){req_data_i[15:0]}};
      SZ_W, SZ_WU: req_wdata_o = {(XLEN/32){req_data_i[31:0]}};
      default:     req_wdata_o = req_data_i;
    endcase
  end

  // Move the addressed lane down to bit 0 before extension.
  assign rsp_lane = rsp_rdata_i >> {rsp_off_i, 3'b000};

  // Load extension: signed sizes sign-extend, unsigned sizes zero-extend.
  always_comb begin
    rsp_data_o = rsp_lane;
    case (rsp_size_i)
      SZ_B:    rsp_data_o = XLEN'($signed(rsp_lane[7:0]));
      SZ_H:    rsp_data_o = XLEN'($signed(rsp_lane[15:0]));
      SZ_W:    rsp_data_o = XLEN'($signed(rsp_lane[31:0]));
      SZ_BU:   rsp_data_o = XLEN'(rsp_lane[7:0]);
      SZ_HU:   rsp_data_o = XLEN'(rsp_lane[15:0]);
      SZ_WU:   rsp_data_o = XLEN'(rsp_lane[31:0]);
      default: rsp_data_o = rsp_lane;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu_hs.sv
// MIRISCV load/store unit with a req/gnt/rvalid memory handshake.
// Accepts one access at a time from the core, stalls the core until the
// memory response arrives, and returns extended load data in a register.
module miriscv_lsu_hs
  import miriscv_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              arst_i,
  // core side
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_size_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [XLEN-1:0]   lsu_data_i,
  output logic [XLEN-1:0]   lsu_data_o,
  output logic              lsu_stall_req_o,
  output logic              lsu_fault_o,
  // memory side
  miriscv_lsu_hs_if.master  data_if
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);

  lsu_state_e        state_q, state_d;

  // Attributes of the outstanding access, captured on acceptance.
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  lsu_size_e         size_q;
  logic [BE_W-1:0]   be_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   ld_data_q;

  lsu_size_e         req_size;
  logic              req_legal;
  logic [BE_W-1:0]   req_be;
  logic [XLEN-1:0]   req_wdata;
  logic [XLEN-1:0]   rsp_data;

  logic              capture;
  logic              load_wr;
  logic              issue_req;
  logic              stall;
  logic              fault;

  assign req_size = lsu_size_e'(lsu_size_i);

  miriscv_lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .req_size_i  (req_size),
    .req_off_i   (lsu_addr_i[OFF_W-1:0]),
    .req_data_i  (lsu_data_i),
    .req_legal_o (req_legal),
    .req_be_o    (req_be),
    .req_wdata_o (req_wdata),
    .rsp_size_i  (size_q),
    .rsp_off_i   (addr_q[OFF_W-1:0]),
    .rsp_rdata_i (data_if.rdata),
    .rsp_data_o  (rsp_data)
  );

  // State register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of block ordering.
      state_q <= state_d;
    end
  end

  // Next-state: grant moves ISSUE on, the response moves WAIT on, DONE lasts
  // exactly one cycle. Responses seen outside WAIT are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (lsu_req_i && req_legal) state_d = ST_ISSUE;
      ST_ISSUE: if (data_if.gnt)            state_d = ST_WAIT;
      ST_WAIT:  if (data_if.rvalid)         state_d = ST_DONE;
      ST_DONE:                              state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  // Outputs per state. Stall and fault are masked while reset is asserted,
  // since an IDLE-state request would otherwise drive them combinationally.
  always_comb begin
    capture   = 1'b0;
    load_wr   = 1'b0;
    issue_req = 1'b0;
    stall     = 1'b0;
    fault     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lsu_req_i && !arst_i) begin
          capture = req_legal;
          stall   = req_legal;
          fault   = !req_legal;
        end
      end
      ST_ISSUE: begin
        stall     = 1'b1;
        issue_req = 1'b1;
      end
      ST_WAIT: begin
        stall   = 1'b1;
        load_wr = data_if.rvalid && !we_q;
      end
      default: ;
    endcase
  end

  // Request attributes: captured once on acceptance and held stable through
  // ISSUE so the memory sees an unchanging request while it withholds grant.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      // NOTE: these registers drive the memory bus directly, so they are
      // cleared by reset to present an all-zero bus immediately.
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      addr_q  <= lsu_addr_i;
      we_q    <= lsu_we_i;
      size_q  <= req_size;
      be_q    <= req_be;
      wdata_q <= req_wdata;
    end
  end

  // Load result register: written only by a load response, so it keeps the
  // last loaded value across stores and idle periods.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ld_data_q <= '0;
    end else if (load_wr) begin
      ld_data_q <= rsp_data;
    end
  end

  assign lsu_data_o      = ld_data_q;
  assign lsu_stall_req_o = stall;
  assign lsu_fault_o     = fault;

  assign data_if.req   = issue_req;
  assign data_if.we    = we_q;
  assign data_if.addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign data_if.be    = be_q;
  assign data_if.wdata = wdata_q;

endmodule

// File: tb/tb_miriscv_lsu_hs.sv
// Self-checking bench for miriscv_lsu_hs: one 32-bit and one 64-bit instance
// share stimulus; sel64 chooses which one receives the core request and which
// one's outputs are observed. Expected values come from a byte-level model.
module tb_miriscv_lsu_hs;

  logic        clk;
  logic        arst;
  logic        sel64;
  logic        req, we;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [63:0] wdat;
  logic        gnt, rvalid;
  logic [63:0] rdata;

  logic [31:0] data32;
  logic [63:0] data64;
  logic        stall32, stall64, fault32, fault64;

  logic        o_stall, o_fault, o_req, o_we;
  logic [31:0] o_addr;
  logic [7:0]  o_be;
  logic [63:0] o_wdata, o_data;

  int          checks;
  int          errors;
  logic [63:0] last32, last64;

  miriscv_lsu_hs_if #(.XLEN(32), .ADDR_W(32)) bus32 ();
  miriscv_lsu_hs_if #(.XLEN(64), .ADDR_W(32)) bus64 ();

  assign bus32.gnt    = gnt;
  assign bus32.rvalid = rvalid;
  assign bus32.rdata  = rdata[31:0];
  assign bus64.gnt    = gnt;
  assign bus64.rvalid = rvalid;
  assign bus64.rdata  = rdata;

  miriscv_lsu_hs #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk_i           (clk),
    .arst_i          (arst),
    .lsu_req_i       (req & ~sel64),
    .lsu_we_i        (we),
    .lsu_size_i      (size),
    .lsu_addr_i      (addr),
    .lsu_data_i      (wdat[31:0]),
    .lsu_data_o      (data32),
    .lsu_stall_req_o (stall32),
    .lsu_fault_o     (fault32),
    .data_if         (bus32)
  );

  miriscv_lsu_hs #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk_i           (clk),
    .arst_i          (arst),
    .lsu_req_i       (req & sel64),
    .lsu_we_i        (we),
    .lsu_size_i      (size),
    .lsu_addr_i      (addr),
    .lsu_data_i      (wdat),
    .lsu_data_o      (data64),
    .lsu_stall_req_o (stall64),
    .lsu_fault_o     (fault64),
    .data_if         (bus64)
  );

  assign o_stall = sel64 ? stall64     : stall32;
  assign o_fault = sel64 ? fault64     : fault32;
  assign o_req   = sel64 ? bus64.req   : bus32.req;
  assign o_we    = sel64 ? bus64.we    : bus32.we;
  assign o_addr  = sel64 ? bus64.addr  : bus32.addr;
  assign o_be    = sel64 ? bus64.be    : {4'b0, bus32.be};
  assign o_wdata = sel64 ? bus64.wdata : {32'b0, bus32.wdata};
  assign o_data  = sel64 ? data64      : {32'b0, data32};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model (byte-level arithmetic) ----------------
  function automatic int nbytes(input logic [2:0] sz);
    case (sz)
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      3'd3:       return 8;
      default:    return 1;
    endcase
  endfunction

  function automatic bit m_legal(input bit is64, input logic [2:0] sz, input logic [31:0] a);
    if (sz == 3'd7) return 1'b0;
    if (!is64 && (sz == 3'd3 || sz == 3'd6)) return 1'b0;
    return (a % nbytes(sz)) == 0;
  endfunction

  function automatic logic [63:0] m_be(input bit is64, input logic [2:0] sz, input logic [31:0] a);
    int bw = is64 ? 8 : 4;
    int off = int'(a % bw);
    logic [63:0] r = '0;
    for (int i = 0; i < nbytes(sz); i++) r[off + i] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] m_wdata(input bit is64, input logic [2:0] sz, input logic [63:0] d);
    int bw = is64 ? 8 : 4;
    logic [63:0] r = '0;
    for (int i = 0; i < bw; i++) r[8*i +: 8] = d[8*(i % nbytes(sz)) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_load(input bit is64, input logic [2:0] sz, input logic [31:0] a,
                                         input logic [63:0] rd);
    int bw = is64 ? 8 : 4;
    int off = int'(a % bw);
    int n = nbytes(sz);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off + i) +: 8];
    if (sz < 3'd4 && v[8*n - 1])
      for (int j = 8*n; j < 8*bw; j++) v[j] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] m_addr(input bit is64, input logic [31:0] a);
    return is64 ? (a & ~32'd7) : (a & ~32'd3);
  endfunction

  // ---------------- one complete core access ----------------
  task automatic run_txn(input string tag, input bit is64, input bit w, input logic [2:0] sz,
                         input logic [31:0] a, input logic [63:0] d, input logic [63:0] rd,
                         input int gd, input int rvd, input bit drop_req);
    bit          legal = m_legal(is64, sz, a);
    logic [63:0] exp_be = m_be(is64, sz, a);
    logic [63:0] exp_wd = m_wdata(is64, sz, d);
    logic [31:0] exp_a  = m_addr(is64, a);
    logic [63:0] exp_ld;
    int          stalls = 0;

    @(posedge clk); #1;
    sel64 = is64; req = 1'b1; we = w; size = sz; addr = a; wdat = d; gnt = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_stall !== legal || o_fault !== !legal || o_req !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: stall=%b fault=%b req=%b, expected stall=%b fault=%b req=0",
               tag, o_stall, o_fault, o_req, legal, !legal);
    end
    if (!legal) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        checks++;
        if (o_req !== 1'b0 || o_fault !== 1'b1 || o_stall !== 1'b0) begin
          errors++;
          $display("FAIL %s fault_hold: req=%b fault=%b stall=%b, expected req=0 fault=1 stall=0",
                   tag, o_req, o_fault, o_stall);
        end
      end
      @(posedge clk); #1;
      req = 1'b0;
      return;
    end
    if (o_stall === 1'b1) stalls++;

    // ISSUE: core-side inputs are scrambled; the bus must keep the captured access.
    for (int k = 0; k <= gd; k++) begin
      @(posedge clk); #1;
      gnt    = (k == gd);
      rvalid = (k < gd) ? 1'($urandom_range(0, 1)) : 1'b0;
      rdata  = {$urandom, $urandom};
      addr   = $urandom; wdat = {$urandom, $urandom}; size = 3'($urandom); we = 1'($urandom);
      if (drop_req) req = 1'b0;
      @(negedge clk);
      if (o_stall === 1'b1) stalls++;
      checks++;
      if (o_req !== 1'b1 || o_fault !== 1'b0 || o_we !== w || o_addr !== exp_a || o_be !== exp_be[7:0] ||
          (w && o_wdata !== exp_wd)) begin
        errors++;
        $display("FAIL %s issue[%0d]: req=%b fault=%b we=%b addr=%h be=%h wdata=%h, expected req=1 fault=0 we=%b addr=%h be=%h wdata=%h",
                 tag, k, o_req, o_fault, o_we, o_addr, o_be, o_wdata, w, exp_a, exp_be[7:0], exp_wd);
      end
    end

    // WAIT: request dropped, response may be delayed, load result not yet visible.
    for (int k = 0; k <= rvd; k++) begin
      @(posedge clk); #1;
      gnt    = 1'b0;
      rvalid = (k == rvd);
      rdata  = (k == rvd) ? rd : {$urandom, $urandom};
      @(negedge clk);
      if (o_stall === 1'b1) stalls++;
      checks++;
      if (o_req !== 1'b0 || o_stall !== 1'b1 || o_data !== (is64 ? last64 : last32)) begin
        errors++;
        $display("FAIL %s wait[%0d]: req=%b stall=%b data=%h, expected req=0 stall=1 data=%h",
                 tag, k, o_req, o_stall, o_data, is64 ? last64 : last32);
      end
    end

    // DONE: one stall-free cycle with the result visible; no new acceptance.
    @(posedge clk); #1;
    rvalid = 1'b0;
    rdata  = {$urandom, $urandom};
    if (!w) begin
      exp_ld = m_load(is64, sz, a, rd);
      if (is64) last64 = exp_ld; else last32 = exp_ld;
    end
    @(negedge clk);
    if (o_stall === 1'b1) stalls++;
    checks++;
    if (o_stall !== 1'b0 || o_req !== 1'b0 || o_data !== (is64 ? last64 : last32)) begin
      errors++;
      $display("FAIL %s done: stall=%b req=%b data=%h, expected stall=0 req=0 data=%h",
               tag, o_stall, o_req, o_data, is64 ? last64 : last32);
    end
    @(posedge clk); #1;
    req = 1'b0;
    checks++;
    if (stalls !== 3 + gd + rvd) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d, expected %0d", tag, stalls, 3 + gd + rvd);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 arst = 1'b1;
    req = 1'b1; we = 1'b0; size = 3'd2; addr = 32'h100;
    #2;
    for (int s = 0; s < 2; s++) begin
      sel64 = (s == 1);
      #1;
      checks++;
      if (o_stall !== 1'b0 || o_fault !== 1'b0 || o_req !== 1'b0 || o_we !== 1'b0 || o_addr !== 32'h0 ||
          o_be !== 8'h0 || o_wdata !== 64'h0 || o_data !== 64'h0) begin
        errors++;
        $display("FAIL reset_state[%0d]: stall=%b fault=%b req=%b we=%b addr=%h be=%h wdata=%h data=%h, expected all zero",
                 s, o_stall, o_fault, o_req, o_we, o_addr, o_be, o_wdata, o_data);
      end
      size = 3'd7;
      #1;
      checks++;
      if (o_fault !== 1'b0 || o_stall !== 1'b0) begin
        errors++;
        $display("FAIL reset_fault_mask[%0d]: fault=%b stall=%b, expected 0 0", s, o_fault, o_stall);
      end
      size = 3'd2;
    end
    req = 1'b0; size = 3'd0; addr = 32'h0; sel64 = 1'b0;
    @(negedge clk);
    arst = 1'b0;
    last32 = '0; last64 = '0;
  endtask

  task automatic test_spec_vectors();
    run_txn("lw_deadbeef", 1'b0, 1'b0, 3'd2, 32'h100, 64'h0, 64'hDEADBEEF, 0, 0, 1'b0);
    checks++;
    if (o_data !== 64'hDEADBEEF || o_be !== 8'h0F) begin
      errors++;
      $display("FAIL lw_deadbeef_result: data=%h be=%h, expected data=00000000deadbeef be=0f", o_data, o_be);
    end
    run_txn("lb_sign", 1'b0, 1'b0, 3'd0, 32'h103, 64'h0, 64'h80FFFF00, 0, 0, 1'b0);
    checks++;
    if (o_data !== 64'hFFFFFF80 || o_be !== 8'h08) begin
      errors++;
      $display("FAIL lb_sign_result: data=%h be=%h, expected data=00000000ffffff80 be=08", o_data, o_be);
    end
    run_txn("lbu_zero", 1'b0, 1'b0, 3'd4, 32'h103, 64'h0, 64'h80FFFF00, 0, 0, 1'b0);
    checks++;
    if (o_data !== 64'h80) begin
      errors++;
      $display("FAIL lbu_zero_result: data=%h, expected 0000000000000080", o_data);
    end
    run_txn("sh_repl", 1'b0, 1'b1, 3'd1, 32'h202, 64'h1234ABCD, 64'h0, 0, 0, 1'b0);
    checks++;
    if (o_be !== 8'h0C || o_wdata !== 64'hABCDABCD || o_addr !== 32'h200 || o_data !== 64'h80) begin
      errors++;
      $display("FAIL sh_repl_result: be=%h wdata=%h addr=%h data=%h, expected be=0c wdata=abcdabcd addr=200 data=80",
               o_be, o_wdata, o_addr, o_data);
    end
    run_txn("lh_misaligned", 1'b0, 1'b0, 3'd1, 32'h101, 64'h0, 64'h0, 0, 0, 1'b0);
    run_txn("ld_on_rv32", 1'b0, 1'b0, 3'd3, 32'h100, 64'h0, 64'h0, 0, 0, 1'b0);
    run_txn("size7", 1'b1, 1'b1, 3'd7, 32'h100, 64'h0, 64'h0, 0, 0, 1'b0);
    run_txn("lwu_64", 1'b1, 1'b0, 3'd6, 32'h104, 64'h0, 64'h8765_4321_0000_0000, 0, 0, 1'b0);
    checks++;
    if (o_data !== 64'h0000_0000_8765_4321) begin
      errors++;
      $display("FAIL lwu_64_result: data=%h, expected 0000000087654321", o_data);
    end
    run_txn("sd_64", 1'b1, 1'b1, 3'd3, 32'h108, 64'h0123_4567_89AB_CDEF, 64'h0, 2, 1, 1'b0);
  endtask

  task automatic test_abort();
    logic [63:0] d = {$urandom, $urandom};
    logic [63:0] exp_wd = m_wdata(1'b0, 3'd2, d);
    @(posedge clk); #1;
    sel64 = 1'b0; req = 1'b1; we = 1'b1; size = 3'd2; addr = 32'h300; wdat = d; gnt = 1'b0; rvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      wdat = {$urandom, $urandom};
      @(negedge clk);
      checks++;
      if (o_req !== 1'b1 || o_stall !== 1'b1 || o_we !== 1'b1 || o_addr !== 32'h300 || o_be !== 8'h0F ||
          o_wdata !== exp_wd) begin
        errors++;
        $display("FAIL gnt_withheld[%0d]: req=%b stall=%b we=%b addr=%h be=%h wdata=%h, expected 1 1 1 300 0f %h",
                 k, o_req, o_stall, o_we, o_addr, o_be, o_wdata, exp_wd);
      end
    end
    @(posedge clk); #1; gnt = 1'b1;
    @(posedge clk); #1; gnt = 1'b0;
    @(negedge clk);
    checks++;
    if (o_stall !== 1'b1 || o_req !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_wait: stall=%b req=%b, expected stall=1 req=0", o_stall, o_req);
    end
    #1 arst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel64 = (s == 1);
      #1;
      checks++;
      if (o_stall !== 1'b0 || o_fault !== 1'b0 || o_req !== 1'b0 || o_we !== 1'b0 || o_addr !== 32'h0 ||
          o_be !== 8'h0 || o_wdata !== 64'h0 || o_data !== 64'h0) begin
        errors++;
        $display("FAIL abort_reset[%0d]: stall=%b fault=%b req=%b we=%b addr=%h be=%h wdata=%h data=%h, expected all zero",
                 s, o_stall, o_fault, o_req, o_we, o_addr, o_be, o_wdata, o_data);
      end
    end
    arst = 1'b0; sel64 = 1'b0; req = 1'b0;
    last32 = '0; last64 = '0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      gnt = (k == 0); rvalid = (k == 0); rdata = {$urandom, $urandom};
      @(negedge clk);
      checks++;
      if (o_req !== 1'b0 || o_stall !== 1'b0 || o_data !== 64'h0) begin
        errors++;
        $display("FAIL late_response[%0d]: req=%b stall=%b data=%h, expected 0 0 0", k, o_req, o_stall, o_data);
      end
    end
    gnt = 1'b0; rvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_lw", 1'b0, 1'b0, 3'd2, 32'h40, 64'h0, 64'hCAFE_F00D, 0, 0, 1'b0);
    run_txn("b2b_sw", 1'b0, 1'b1, 3'd2, 32'h44, 64'h5555_AAAA, 64'h0, 0, 0, 1'b0);
    run_txn("b2b_sb", 1'b0, 1'b1, 3'd0, 32'h45, 64'h77, 64'h0, 1, 0, 1'b1);
    checks++;
    if (o_data !== 64'hCAFE_F00D) begin
      errors++;
      $display("FAIL store_keeps_load: data=%h, expected 00000000cafef00d", o_data);
    end
    run_txn("b2b_lh64", 1'b1, 1'b0, 3'd1, 32'h46, 64'h0, 64'h8001_0000_0000_0000, 0, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      bit          is64 = 1'($urandom);
      logic [2:0]  sz   = 3'($urandom_range(0, 7));
      logic [31:0] a    = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(sz)) - 32'd1);
      run_txn("random", is64, 1'($urandom), sz, a, {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    arst = 1'b0; sel64 = 1'b0; req = 1'b0; we = 1'b0; size = 3'd0; addr = '0; wdat = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0; last32 = '0; last64 = '0;
    test_reset();
    test_spec_vectors();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
